alu_seq: RTL and testbench

- Parametrised, registered successor to the team's 6-bit combinational ALU.
- Keeps the same opcode map (add, sub, equality, greater-than, less-than, equal-zero) and adds an iterative unsigned multiply.
- Adds carry/overflow and zero flags.
- Uses valid/ready handshakes on input and output, so it sits between a register-file read stage and a writeback stage.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_seq_mul.sv | 56 +++++
 rtl/alu_seq.sv | 111 +++++++++++
 tb/tb_alu_seq.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU.
// Latency: none (types only).
// Backpressure: not applicable.
package alu_pkg;

  // Opcode map kept identical to the original combinational ALU, plus MUL in the spare slot
  typedef enum logic [2:0] {
    ADD  = 3'b000,
    SUB  = 3'b001,
    MUL  = 3'b010,
    RSVD = 3'b011,
    EQ   = 3'b100,
    GT   = 3'b101,
    LT   = 3'b110,
    EQZ  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } alu_state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Latency: start edge + WIDTH steps; done is high in the cycle after the last step.
// Backpressure: none; the owner holds off new starts until done has been consumed.
module alu_seq_mul #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               running;

  // Latch operands on start, then add the shifted multiplicand for each set multiplier bit
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      mcand   <= {{WIDTH{1'b0}}, A};
      mplier  <= B;
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (cnt == CW'(WIDTH)) begin
        // Product has been observed by the owner this cycle; go quiet
        running <= 1'b0;
      end else begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
      end
    end
  end

  assign done    = running && (cnt == CW'(WIDTH));
  assign product = acc;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides; MUL is iterative, all other ops single-cycle.
// Latency: 1 cycle for non-MUL ops, WIDTH+1 cycles for MUL (accept edge to out_valid).
// Backpressure: a held result stalls the input; in_ready follows out_ready while a result is pending.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             overflow,
  output logic             zero
);

  alu_state_e         state;
  alu_op_e            op;
  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   res_c;
  logic               res_ovf;

  assign op = alu_op_e'(sel);

  // A pending result only frees the input when it is leaving in the same cycle
  assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == MUL);
  assign sum       = {1'b0, A} + {1'b0, B};

  alu_seq_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .A      (A),
    .B      (B),
    .done   (mul_done),
    .product(mul_product)
  );

  // Single-cycle datapath for everything except MUL, which is resolved by the multiplier
  always_comb begin
    res_c   = '0;
    res_ovf = 1'b0;
    case (op)
      ADD: begin
        res_c   = sum[WIDTH-1:0];
        res_ovf = sum[WIDTH];
      end
      SUB: begin
        res_c   = A - B;
        res_ovf = (A < B);
      end
      EQ:  res_c = {{(WIDTH-1){1'b0}}, (A == B)};
      GT:  res_c = {{(WIDTH-1){1'b0}}, (A > B)};
      LT:  res_c = {{(WIDTH-1){1'b0}}, (A < B)};
      EQZ: res_c = {{(WIDTH-1){1'b0}}, (A == '0)};
      default: begin
        res_c   = '0;
        res_ovf = 1'b0;
      end
    endcase
  end

  // Control FSM and output registers; accept can only fire from IDLE or a draining DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      C         <= '0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (accept) begin
      if (op == MUL) begin
        state     <= BUSY;
        out_valid <= 1'b0;
      end else begin
        state     <= DONE;
        out_valid <= 1'b1;
        C         <= res_c;
        overflow  <= res_ovf;
        zero      <= (res_c == '0);
      end
    end else if ((state == BUSY) && mul_done) begin
      state     <= DONE;
      out_valid <= 1'b1;
      C         <= mul_product[WIDTH-1:0];
      overflow  <= |mul_product[2*WIDTH-1:WIDTH];
      zero      <= (mul_product[WIDTH-1:0] == '0);
    end else if ((state == DONE) && out_ready) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else if ((state != IDLE) && (state != BUSY) && (state != DONE)) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=6 and WIDTH=16.
// Directed scenarios plus a randomized run against an arithmetic reference model.
// Drives on edge+1, samples after settling, so values match what the next edge sees.
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       in_valid, in_ready, out_valid, out_ready, overflow, zero;
  logic [5:0] A, B, C;
  logic [2:0] sel;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, overflow16, zero16;
  logic [15:0] A16, B16, C16;
  logic [2:0]  sel16;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(6)) u6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .C(C), .overflow(overflow), .zero(zero)
  );

  alu_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .A(A16), .B(B16), .sel(sel16), .out_valid(out_valid16), .out_ready(out_ready16),
    .C(C16), .overflow(overflow16), .zero(zero16)
  );

  // Reference: plain arithmetic on wide integers, then reduced to w bits
  function automatic void model(input int w, input longint unsigned a, input longint unsigned b,
                                input logic [2:0] s, output longint unsigned c, output logic ovf);
    longint unsigned m;
    longint unsigned r;
    m   = (64'd1 << w) - 64'd1;
    r   = 0;
    ovf = 1'b0;
    case (s)
      3'd0: begin r = a + b; ovf = (r > m); end
      3'd1: begin r = a - b; ovf = (a < b); end
      3'd2: begin r = a * b; ovf = (r > m); end
      3'd4: r = (a == b) ? 64'd1 : 64'd0;
      3'd5: r = (a > b)  ? 64'd1 : 64'd0;
      3'd6: r = (a < b)  ? 64'd1 : 64'd0;
      3'd7: r = (a == 0) ? 64'd1 : 64'd0;
      default: r = 0;
    endcase
    c = r & m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op on the WIDTH=6 port and return just after the accepting edge
  task automatic issue6(input logic [5:0] a, input logic [5:0] b, input logic [2:0] s);
    A = a; B = b; sel = s; in_valid = 1'b1;
    #1;
    for (int i = 0; i < 50 && !in_ready; i++) tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue6 accept: in_ready=%b, required 1 within 50 cycles", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; A = 6'd3; B = 6'd4; sel = 3'd0; out_ready = 1'b1;
    in_valid16 = 1'b1; A16 = 16'd1; B16 = 16'd1; sel16 = 3'd0; out_ready16 = 1'b1;
    tick(); tick();
    checks++;
    if ({in_ready, out_valid, C, overflow, zero} !== 10'd0) begin
      errors++;
      $display("FAIL reset6: rdy=%b vld=%b C=%0d ovf=%b z=%b, required all 0",
               in_ready, out_valid, C, overflow, zero);
    end
    checks++;
    if ({in_ready16, out_valid16, C16, overflow16, zero16} !== 20'd0) begin
      errors++;
      $display("FAIL reset16: rdy=%b vld=%b C=%0d ovf=%b z=%b, required all 0",
               in_ready16, out_valid16, C16, overflow16, zero16);
    end
    rst = 1'b0; in_valid = 1'b0; in_valid16 = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready: got %b required 1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle out_valid: got %b required 0", out_valid);
    end
  endtask

  task automatic test_add();
    longint unsigned ec;
    logic eo;
    out_ready = 1'b1;
    model(6, 40, 30, 3'd0, ec, eo);
    issue6(6'd40, 6'd30, 3'd0);
    checks++;
    if ({out_valid, C, overflow, zero} !== {1'b1, ec[5:0], eo, ec == 0}) begin
      errors++;
      $display("FAIL add: vld=%b C=%0d ovf=%b z=%b, required vld=1 C=%0d ovf=%b z=%b",
               out_valid, C, overflow, zero, ec[5:0], eo, ec == 0);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_drain out_valid: got %b required 0", out_valid);
    end
  endtask

  task automatic test_sub();
    longint unsigned ec;
    logic eo;
    out_ready = 1'b1;
    model(6, 5, 9, 3'd1, ec, eo);
    issue6(6'd5, 6'd9, 3'd1);
    checks++;
    if ({out_valid, C, overflow, zero} !== {1'b1, ec[5:0], eo, ec == 0}) begin
      errors++;
      $display("FAIL sub_borrow: vld=%b C=%0d ovf=%b z=%b, required C=%0d ovf=%b",
               out_valid, C, overflow, zero, ec[5:0], eo);
    end
    model(6, 9, 9, 3'd1, ec, eo);
    issue6(6'd9, 6'd9, 3'd1);
    checks++;
    if ({out_valid, C, overflow, zero} !== {1'b1, ec[5:0], eo, ec == 0}) begin
      errors++;
      $display("FAIL sub_zero: vld=%b C=%0d ovf=%b z=%b, required C=%0d ovf=%b z=1",
               out_valid, C, overflow, zero, ec[5:0], eo);
    end
    tick();
  endtask

  task automatic test_mul();
    longint unsigned ec;
    logic eo;
    int n;
    out_ready = 1'b1;
    model(6, 7, 9, 3'd2, ec, eo);
    issue6(6'd7, 6'd9, 3'd2);
    for (int i = 1; i <= 7; i++) begin
      checks++;
      if ({out_valid, in_ready} !== 2'b00) begin
        errors++;
        $display("FAIL mul_busy cycle %0d: vld=%b rdy=%b, required 0 0", i, out_valid, in_ready);
      end
      tick();
    end
    checks++;
    if ({out_valid, C, overflow, zero} !== {1'b1, ec[5:0], eo, ec == 0}) begin
      errors++;
      $display("FAIL mul_7x9: vld=%b C=%0d ovf=%b z=%b, required vld=1 C=%0d ovf=%b",
               out_valid, C, overflow, zero, ec[5:0], eo);
    end
    model(6, 8, 9, 3'd2, ec, eo);
    issue6(6'd8, 6'd9, 3'd2);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 7) begin
      errors++;
      $display("FAIL mul_latency: got %0d cycles, required 7", n);
    end
    checks++;
    if ({out_valid, C, overflow, zero} !== {1'b1, ec[5:0], eo, ec == 0}) begin
      errors++;
      $display("FAIL mul_8x9: vld=%b C=%0d ovf=%b z=%b, required C=%0d ovf=%b",
               out_valid, C, overflow, zero, ec[5:0], eo);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0] ta[5] = '{6'd12, 6'd12, 6'd0, 6'd3, 6'd17};
    logic [5:0] tb[5] = '{6'd5, 6'd5, 6'd33, 6'd4, 6'd17};
    logic [2:0] ts[5] = '{3'd5, 3'd6, 3'd7, 3'd3, 3'd4};
    longint unsigned ec;
    logic eo;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      A = ta[k]; B = tb[k]; sel = ts[k]; in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready op %0d: got %b required 1", k, in_ready);
      end
      model(6, longint'(ta[k]), longint'(tb[k]), ts[k], ec, eo);
      tick();
      checks++;
      if ({out_valid, C, overflow, zero} !== {1'b1, ec[5:0], eo, ec == 0}) begin
        errors++;
        $display("FAIL b2b op %0d sel=%0d: vld=%b C=%0d ovf=%b z=%b, required C=%0d ovf=%b z=%b",
                 k, ts[k], out_valid, C, overflow, zero, ec[5:0], eo, ec == 0);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain out_valid: got %b required 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    longint unsigned ec;
    logic eo;
    out_ready = 1'b0;
    model(6, 40, 30, 3'd0, ec, eo);
    issue6(6'd40, 6'd30, 3'd0);
    A = 6'd1; B = 6'd2; sel = 3'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({out_valid, C, overflow, zero, in_ready} !== {1'b1, ec[5:0], eo, ec == 0, 1'b0}) begin
        errors++;
        $display("FAIL hold cycle %0d: vld=%b C=%0d ovf=%b z=%b rdy=%b, required 1 %0d %b %b 0",
                 i, out_valid, C, overflow, zero, in_ready, ec[5:0], eo, ec == 0);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release in_ready: got %b required 1", in_ready);
    end
    model(6, 1, 2, 3'd1, ec, eo);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, C, overflow, zero} !== {1'b1, ec[5:0], eo, ec == 0}) begin
      errors++;
      $display("FAIL release_next: vld=%b C=%0d ovf=%b z=%b, required C=%0d ovf=%b",
               out_valid, C, overflow, zero, ec[5:0], eo);
    end
    tick();
  endtask

  task automatic test_reset_mid_mul();
    int stale;
    out_ready = 1'b1;
    issue6(6'd7, 6'd9, 3'd2);
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({out_valid, C, in_ready} !== 8'd0) begin
      errors++;
      $display("FAIL mid_mul_reset: vld=%b C=%0d rdy=%b, required 0 0 0", out_valid, C, in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_mul_release in_ready: got %b required 1", in_ready);
    end
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL mid_mul_stale: out_valid seen %0d cycles, required 0", stale);
    end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] got;
    logic [7:0] want;
    logic [7:0] held_val;
    logic held;
    longint unsigned ec;
    logic eo;
    int acc;
    int cyc;
    acc = 0; cyc = 0; held = 1'b0; held_val = '0;
    while ((acc < 150 || q.size() > 0) && cyc < 4000) begin
      in_valid  = (acc < 150) && ($urandom_range(0, 3) != 0);
      A         = 6'($urandom);
      B         = 6'($urandom);
      sel       = 3'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      got = {C, overflow, zero};
      if (held) begin
        checks++;
        if ({out_valid, got} !== {1'b1, held_val}) begin
          errors++;
          $display("FAIL rand_hold: vld=%b C/ovf/z=%h, required vld=1 %h", out_valid, got, held_val);
        end
      end
      held     = out_valid && !out_ready;
      held_val = got;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_spurious: result C=%0d with nothing outstanding", C);
        end else begin
          want = q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL rand_result: C/ovf/z=%h, required %h", got, want);
          end
        end
      end
      if (in_valid && in_ready) begin
        model(6, longint'(A), longint'(B), sel, ec, eo);
        q.push_back({ec[5:0], eo, ec == 0});
        acc++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (acc != 150 || q.size() != 0) begin
      errors++;
      $display("FAIL rand_complete: accepted %0d outstanding %0d, required 150 and 0", acc, q.size());
    end
  endtask

  task automatic test_w16();
    longint unsigned ec;
    logic eo;
    int n;
    out_ready16 = 1'b1;
    A16 = 16'hFFFF; B16 = 16'd1; sel16 = 3'd0; in_valid16 = 1'b1;
    #1;
    checks++;
    if (in_ready16 !== 1'b1) begin
      errors++;
      $display("FAIL w16_ready: got %b required 1", in_ready16);
    end
    model(16, 64'hFFFF, 1, 3'd0, ec, eo);
    tick();
    in_valid16 = 1'b0;
    checks++;
    if ({out_valid16, C16, overflow16, zero16} !== {1'b1, ec[15:0], eo, ec == 0}) begin
      errors++;
      $display("FAIL w16_add: vld=%b C=%0d ovf=%b z=%b, required C=%0d ovf=%b z=%b",
               out_valid16, C16, overflow16, zero16, ec[15:0], eo, ec == 0);
    end
    tick();
    A16 = 16'd300; B16 = 16'd300; sel16 = 3'd2; in_valid16 = 1'b1;
    model(16, 300, 300, 3'd2, ec, eo);
    tick();
    in_valid16 = 1'b0;
    n = 0;
    while (!out_valid16 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n != 17) begin
      errors++;
      $display("FAIL w16_mul_latency: got %0d cycles, required 17", n);
    end
    checks++;
    if ({out_valid16, C16, overflow16, zero16} !== {1'b1, ec[15:0], eo, ec == 0}) begin
      errors++;
      $display("FAIL w16_mul: vld=%b C=%0d ovf=%b z=%b, required C=%0d ovf=%b",
               out_valid16, C16, overflow16, zero16, ec[15:0], eo);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; A = '0; B = '0; sel = '0; out_ready = 1'b0;
    in_valid16 = 1'b0; A16 = '0; B16 = '0; sel16 = '0; out_ready16 = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_mul();
    test_random();
    test_w16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
